display_refresh_ctrl: RTL and testbench
=======================================

// Module: display_refresh_ctrl
// PURPOSE
//  Sequencer for the dual2ascii binary-to-ASCII converter in the bike computer display path.
//  - Owns the display mode (DAY/AVS/MAX/TIM) and advances it on a mode-button pulse.
//  - Issues a periodic or mode-change start pulse and waits for valid_out.
//  - Captures the six ASCII digits into stable display registers for the LCD driver.
//  - Times out a conversion that never completes.
// PARAMETERS
//  REFRESH_CYCLES  250000  clock cycles between periodic refresh requests (0.5 s at 500 kHz)
//  TIMEOUT_CYCLES  64      max cycles in WAIT before a conversion is abandoned
// PORTS
//  clock         in   1  system clock
//  reset         in   1  asynchronous, active-low reset
//  mode_btn      in   1  debounced single-cycle mode-advance pulse
//  conv_valid    in   1  valid_out from dual2ascii
//  conv_u10      in   8  upper10 ASCII from dual2ascii
//  conv_u01      in   8  upper01 ASCII
//  conv_l1000    in   8  lower1000 ASCII
//  conv_l0100    in   8  lower0100 ASCII
//  conv_l0010    in   8  lower0010 ASCII
//  conv_l0001    in   8  lower0001 ASCII
//  conv_start    out  1  start pulse to dual2ascii
//  DAY/AVS/MAX/TIM out 1 each  one-hot mode select to dual2ascii; stable while busy
//  disp_u10..disp_l0001  out  8 each  latched display digits, same order as conv_*
//  disp_update   out  1  one-cycle pulse when disp_* are reloaded
//  busy          out  1  high in START or WAIT
//  err_timeout   out  1  sticky; set on a WAIT timeout, cleared only by reset
// BEHAVIOUR
//  Reset values:
//   - Mode DAY (DAY=1, others 0).
//   - conv_start=0, disp_update=0, busy=0, err_timeout=0.
//   - All disp_* = 8'h20 (ASCII space).
//   - Refresh counter=0, refresh_pending=1 so the first conversion runs right after reset release.
//  Mode order: DAY -> AVS -> MAX -> TIM -> DAY.
//  Mode updates only in IDLE:
//   - mode_btn in IDLE advances mode at that edge and sets req.
//   - mode_btn while busy sets press_pending; several presses while busy collapse to one advance.
//   - The pending advance is applied on the first IDLE cycle after busy ends.
//  Refresh timer:
//   - Free-running 0..REFRESH_CYCLES-1; sets refresh_pending on wrap.
//   - Multiple wraps collapse; pending clears when START is entered.
//  FSM states IDLE, START, WAIT:
//   - IDLE -> START when refresh_pending or a mode change (button or press_pending) occurs.
//     Refresh and button in the same cycle: advance mode, then run exactly one conversion.
//   - START lasts 1 cycle with conv_start=1. conv_valid is ignored in START. Next state WAIT.
//     WAIT timeout counter is cleared on entry.
//   - WAIT, conv_valid=1: at that edge load all six disp_* from conv_*, disp_update<=1 for the
//     next cycle only, go to IDLE.
//   - WAIT, timeout counter reaches TIMEOUT_CYCLES-1 without conv_valid: go to IDLE, set
//     err_timeout, leave disp_* unchanged, no disp_update. Retry at the next request.
//   - conv_valid outside WAIT is ignored.
//  Latency: request seen in IDLE -> conv_start high 1 cycle later. conv_valid in WAIT ->
//   disp_* and disp_update valid 1 cycle later.
//  Reset asserted mid-conversion: all state returns to reset values immediately; no disp_update.
//  Width rules:
//   - Counters sized with $clog2 of their parameter; both parameters >= 2.
//   - Refresh counter wraps by compare, not by overflow.
// STRUCTURE
//  bike_disp_pkg: mode encoding (MODE_DAY/AVS/MAX/TIM), FSM state encoding, ASCII_SPACE=8'h20.
//  Sub-module disp_refresh_timer: refresh counter plus pending flag; inputs clear and reset,
//   output pending.
//  FSM, mode register, timeout counter and display registers stay in this module.
// TESTING  (bench params: REFRESH_CYCLES=40, TIMEOUT_CYCLES=8; dual2ascii model replies 5 cycles after start)
//  1 Reset release -> conv_start 1 cycle later with DAY=1; disp_* = converter digits, one disp_update.
//  2 No input for 100 cycles -> exactly 2 further conversions, each 40 cycles apart; mode stays DAY.
//  3 mode_btn in IDLE -> AVS=1 at next edge, conv_start next cycle, disp_* updated to AVS digits.
//  4 Three mode_btn pulses during WAIT -> mode unchanged until done, then one advance only
//    (AVS->MAX) plus one new conversion.
//  5 Model never raises valid -> busy drops 9 cycles after start, err_timeout=1, disp_* unchanged;
//    conversion retried at the next refresh.
//  6 Reset asserted in WAIT, conv_valid arriving 1 cycle later -> disp_*=8'h20, no disp_update, DAY=1.

Source files
------------

// File: rtl/bike_disp_pkg.sv
// Purpose: shared encodings for the bike computer display refresh path.
//   mode_t      display mode, advanced DAY -> AVS -> MAX -> TIM -> DAY
//   state_t     refresh sequencer states
//   ASCII_SPACE blank digit shown until the first conversion lands
package bike_disp_pkg;

  typedef enum logic [1:0] {
    MODE_DAY = 2'd0,
    MODE_AVS = 2'd1,
    MODE_MAX = 2'd2,
    MODE_TIM = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_DAY: next_mode = MODE_AVS;
      MODE_AVS: next_mode = MODE_MAX;
      MODE_MAX: next_mode = MODE_TIM;
      default:  next_mode = MODE_DAY;
    endcase
  endfunction

endpackage

// File: rtl/disp_refresh_timer.sv
// Purpose: free-running refresh interval counter with a sticky request flag.
// Ports:
//   clock    in   system clock
//   reset    in   asynchronous active-low reset
//   clear    in   request consumed (sequencer entering START)
//   pending  out  a refresh interval has elapsed since the last clear
// The flag comes out of reset set so the display is filled immediately.
module disp_refresh_timer
  import bike_disp_pkg::*;
#(
  parameter int REFRESH_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic pending
);

  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] count;
  logic          wrap;

  assign wrap = (count == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      pending <= 1'b1;
    end else begin
      count <= wrap ? '0 : count + 1'b1;
      // a wrap coinciding with a clear must not be lost
      if (wrap)
        pending <= 1'b1;
      else if (clear)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/display_refresh_ctrl.sv
// Purpose: sequencer for the dual2ascii converter feeding the LCD.
//   Owns the display mode, launches a conversion on periodic refresh or a
//   mode change, captures the six ASCII digits and flags stuck conversions.
// Ports:
//   clock, reset              system clock, asynchronous active-low reset
//   mode_btn                  single-cycle mode-advance pulse
//   conv_valid, conv_*        converter result handshake and six ASCII digits
//   conv_start                one-cycle start pulse to the converter
//   DAY/AVS/MAX/TIM           one-hot mode select, stable while busy
//   disp_*                    latched display digits, same order as conv_*
//   disp_update               one-cycle pulse when disp_* reload
//   busy                      conversion in flight (START or WAIT)
//   err_timeout               sticky, converter failed to answer in time
//
// state | meaning
// IDLE  | waiting for refresh request or mode change
// START | conv_start asserted for one cycle
// WAIT  | waiting for conv_valid, bounded by the timeout counter
module display_refresh_ctrl
  import bike_disp_pkg::*;
#(
  parameter int REFRESH_CYCLES = 250000,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       conv_valid,
  input  logic [7:0] conv_u10,
  input  logic [7:0] conv_u01,
  input  logic [7:0] conv_l1000,
  input  logic [7:0] conv_l0100,
  input  logic [7:0] conv_l0010,
  input  logic [7:0] conv_l0001,
  output logic       conv_start,
  output logic       DAY,
  output logic       AVS,
  output logic       MAX,
  output logic       TIM,
  output logic [7:0] disp_u10,
  output logic [7:0] disp_u01,
  output logic [7:0] disp_l1000,
  output logic [7:0] disp_l0100,
  output logic [7:0] disp_l0010,
  output logic [7:0] disp_l0001,
  output logic       disp_update,
  output logic       busy,
  output logic       err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  mode_t         mode;
  logic          press_pending;
  logic [TW-1:0] tcnt;
  logic          refresh_pending;
  logic          timer_clear;
  logic          adv_mode;
  logic          load_disp;
  logic          set_err;

  disp_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .pending(refresh_pending)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    timer_clear = 1'b0;
    adv_mode    = 1'b0;
    load_disp   = 1'b0;
    set_err     = 1'b0;
    case (state)
      ST_IDLE: begin
        // a mode change also satisfies any refresh request: one conversion
        if (mode_btn || press_pending) begin
          adv_mode    = 1'b1;
          timer_clear = 1'b1;
          state_nxt   = ST_START;
        end else if (refresh_pending) begin
          timer_clear = 1'b1;
          state_nxt   = ST_START;
        end
      end
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (conv_valid) begin
          load_disp = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tcnt == T_LAST) begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode          <= MODE_DAY;
      press_pending <= 1'b0;
      tcnt          <= '0;
      err_timeout   <= 1'b0;
      disp_update   <= 1'b0;
      disp_u10      <= ASCII_SPACE;
      disp_u01      <= ASCII_SPACE;
      disp_l1000    <= ASCII_SPACE;
      disp_l0100    <= ASCII_SPACE;
      disp_l0010    <= ASCII_SPACE;
      disp_l0001    <= ASCII_SPACE;
    end else begin
      if (adv_mode)
        mode <= next_mode(mode);

      // presses during a conversion collapse into a single deferred advance
      if (state != ST_IDLE && mode_btn)
        press_pending <= 1'b1;
      else if (adv_mode)
        press_pending <= 1'b0;

      if (state == ST_START)
        tcnt <= '0;
      else if (state == ST_WAIT)
        tcnt <= tcnt + 1'b1;

      if (set_err)
        err_timeout <= 1'b1;

      disp_update <= load_disp;
      if (load_disp) begin
        disp_u10   <= conv_u10;
        disp_u01   <= conv_u01;
        disp_l1000 <= conv_l1000;
        disp_l0100 <= conv_l0100;
        disp_l0010 <= conv_l0010;
        disp_l0001 <= conv_l0001;
      end
    end
  end

  assign conv_start = (state == ST_START);
  assign busy       = (state != ST_IDLE);
  assign DAY        = (mode == MODE_DAY);
  assign AVS        = (mode == MODE_AVS);
  assign MAX        = (mode == MODE_MAX);
  assign TIM        = (mode == MODE_TIM);

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// Bench for display_refresh_ctrl with a dual2ascii stand-in that answers
// five cycles after conv_start; expected digits are queued when the model
// answers and compared when disp_update fires.
module tb_display_refresh_ctrl;
  import bike_disp_pkg::*;

  localparam int REFRESH = 40;
  localparam int TIMEOUT = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode_btn;
  logic       conv_valid;
  logic [7:0] conv_u10, conv_u01, conv_l1000, conv_l0100, conv_l0010, conv_l0001;
  logic       conv_start, DAY, AVS, MAX, TIM;
  logic [7:0] disp_u10, disp_u01, disp_l1000, disp_l0100, disp_l0010, disp_l0001;
  logic       disp_update, busy, err_timeout;

  logic        model_valid;
  logic        tb_valid;
  logic [47:0] model_digits;
  logic [47:0] tb_digits;
  logic [47:0] disp_all;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [47:0] sb_q[$];
  logic [47:0] sb_exp;
  logic [47:0] last_disp = {6{8'h20}};
  int          upd_count = 0;
  int          start_count = 0;
  int          last_start_cyc = 0;
  int          start_gap = 0;
  int          cyc = 0;
  int          seq = 0;
  mode_t       exp_mode;
  mode_t       m_cap;
  bit          model_reply;

  assign conv_valid = model_valid | tb_valid;
  assign {conv_u10, conv_u01, conv_l1000, conv_l0100, conv_l0010, conv_l0001} =
         tb_valid ? tb_digits : model_digits;
  assign disp_all = {disp_u10, disp_u01, disp_l1000, disp_l0100, disp_l0010, disp_l0001};

  display_refresh_ctrl #(
    .REFRESH_CYCLES(REFRESH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mode_btn   (mode_btn),
    .conv_valid (conv_valid),
    .conv_u10   (conv_u10),
    .conv_u01   (conv_u01),
    .conv_l1000 (conv_l1000),
    .conv_l0100 (conv_l0100),
    .conv_l0010 (conv_l0010),
    .conv_l0001 (conv_l0001),
    .conv_start (conv_start),
    .DAY        (DAY),
    .AVS        (AVS),
    .MAX        (MAX),
    .TIM        (TIM),
    .disp_u10   (disp_u10),
    .disp_u01   (disp_u01),
    .disp_l1000 (disp_l1000),
    .disp_l0100 (disp_l0100),
    .disp_l0010 (disp_l0010),
    .disp_l0001 (disp_l0001),
    .disp_update(disp_update),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  function automatic logic [3:0] mode_onehot(input mode_t m);
    case (m)
      MODE_DAY: mode_onehot = 4'b1000;
      MODE_AVS: mode_onehot = 4'b0100;
      MODE_MAX: mode_onehot = 4'b0010;
      default:  mode_onehot = 4'b0001;
    endcase
  endfunction

  function automatic logic [47:0] make_digits(input mode_t m, input int idx);
    logic [7:0] letter;
    case (m)
      MODE_DAY: letter = 8'h44;
      MODE_AVS: letter = 8'h41;
      MODE_MAX: letter = 8'h4D;
      default:  letter = 8'h54;
    endcase
    make_digits = {letter, 8'(48 + idx % 10), 8'(48 + (idx + 1) % 10),
                   8'(48 + (idx + 2) % 10), 8'(48 + (idx + 3) % 10), 8'(48 + (idx + 4) % 10)};
  endfunction

  // converter model: checks the mode at each start and answers 5 cycles later
  initial begin
    model_valid  = 1'b0;
    model_digits = '0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && conv_start === 1'b1) begin
        start_count++;
        start_gap      = cyc - last_start_cyc;
        last_start_cyc = cyc;
        total_cnt++;
        if ({DAY, AVS, MAX, TIM} !== mode_onehot(exp_mode))
          $display("FAIL mode_at_start: got %b expected %b", {DAY, AVS, MAX, TIM}, mode_onehot(exp_mode));
        else
          pass_cnt++;
        if (model_reply) begin
          m_cap = exp_mode;
          repeat (5) @(negedge clock);
          model_digits = make_digits(m_cap, seq);
          seq++;
          sb_q.push_back(model_digits);
          model_valid = 1'b1;
          @(negedge clock);
          model_valid = 1'b0;
        end
      end
    end
  end

  // scoreboard: every display reload must match the oldest queued answer
  initial begin
    forever begin
      @(negedge clock);
      if (disp_update === 1'b1) begin
        upd_count++;
        total_cnt++;
        if (sb_q.size() == 0) begin
          $display("FAIL disp_update_unexpected: got update with digits %h, expected none", disp_all);
        end else begin
          sb_exp    = sb_q.pop_front();
          last_disp = sb_exp;
          if (disp_all !== sb_exp)
            $display("FAIL disp_digits: got %h expected %h", disp_all, sb_exp);
          else
            pass_cnt++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic wait_start(input int max, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max) begin
      @(negedge clock);
      n++;
      if (conv_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_update(input int max, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max) begin
      @(negedge clock);
      n++;
      if (disp_update === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset       = 1'b0;
    mode_btn    = 1'b0;
    tb_valid    = 1'b0;
    tb_digits   = '0;
    model_reply = 1'b1;
    exp_mode    = MODE_DAY;
    repeat (3) @(negedge clock);
    total_cnt++;
    if ({DAY, AVS, MAX, TIM} !== 4'b1000) $display("FAIL reset_mode: got %b expected 1000", {DAY, AVS, MAX, TIM});
    else pass_cnt++;
    total_cnt++;
    if (conv_start !== 1'b0) $display("FAIL reset_conv_start: got %b expected 0", conv_start);
    else pass_cnt++;
    total_cnt++;
    if (disp_update !== 1'b0) $display("FAIL reset_disp_update: got %b expected 0", disp_update);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (err_timeout !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_timeout);
    else pass_cnt++;
    total_cnt++;
    if (disp_all !== {6{8'h20}}) $display("FAIL reset_disp: got %h expected %h", disp_all, {6{8'h20}});
    else pass_cnt++;
  endtask

  task automatic test_first_conversion;
    int n;
    bit ok;
    reset = 1'b1;
    @(negedge clock);
    total_cnt++;
    if (conv_start !== 1'b1) $display("FAIL first_start: got %b expected 1", conv_start);
    else pass_cnt++;
    total_cnt++;
    if ({DAY, AVS, MAX, TIM} !== 4'b1000) $display("FAIL first_mode: got %b expected 1000", {DAY, AVS, MAX, TIM});
    else pass_cnt++;
    wait_update(20, n, ok);
    total_cnt++;
    if (!ok || n != 6) $display("FAIL first_update_latency: got ok=%0d n=%0d expected ok=1 n=6", ok, n);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (upd_count !== 1) $display("FAIL first_update_count: got %0d expected 1", upd_count);
    else pass_cnt++;
  endtask

  task automatic test_periodic;
    int s0, u0;
    s0 = start_count;
    u0 = upd_count;
    repeat (100) @(negedge clock);
    #1;
    total_cnt++;
    if (start_count - s0 !== 2) $display("FAIL periodic_count: got %0d expected 2", start_count - s0);
    else pass_cnt++;
    total_cnt++;
    if (start_gap !== REFRESH) $display("FAIL periodic_gap: got %0d expected %0d", start_gap, REFRESH);
    else pass_cnt++;
    total_cnt++;
    if (upd_count - u0 !== 2) $display("FAIL periodic_updates: got %0d expected 2", upd_count - u0);
    else pass_cnt++;
    total_cnt++;
    if (DAY !== 1'b1) $display("FAIL periodic_mode: got DAY=%b expected 1", DAY);
    else pass_cnt++;
  endtask

  task automatic test_mode_button;
    int n;
    bit ok;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL button_precondition_idle: got busy=%b expected 0", busy);
    else pass_cnt++;
    exp_mode = MODE_AVS;
    mode_btn = 1'b1;
    @(negedge clock);
    mode_btn = 1'b0;
    total_cnt++;
    if ({DAY, AVS, MAX, TIM} !== 4'b0100) $display("FAIL button_mode: got %b expected 0100", {DAY, AVS, MAX, TIM});
    else pass_cnt++;
    total_cnt++;
    if (conv_start !== 1'b1) $display("FAIL button_start: got %b expected 1", conv_start);
    else pass_cnt++;
    wait_update(20, n, ok);
    total_cnt++;
    if (!ok || n != 6) $display("FAIL button_update: got ok=%0d n=%0d expected ok=1 n=6", ok, n);
    else pass_cnt++;
    total_cnt++;
    if (disp_u10 !== 8'h41) $display("FAIL button_digit_letter: got %h expected 41", disp_u10);
    else pass_cnt++;
  endtask

  task automatic test_press_during_wait;
    int n, s1;
    bit ok;
    wait_start(60, n, ok);
    total_cnt++;
    if (!ok) $display("FAIL press_wait_start: got no start within %0d expected start", n);
    else pass_cnt++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      mode_btn = (k % 2 == 1);
    end
    @(negedge clock);
    mode_btn = 1'b0;
    total_cnt++;
    if ({DAY, AVS, MAX, TIM} !== 4'b0100) $display("FAIL press_mode_held: got %b expected 0100", {DAY, AVS, MAX, TIM});
    else pass_cnt++;
    total_cnt++;
    if (disp_update !== 1'b1) $display("FAIL press_update_first: got %b expected 1", disp_update);
    else pass_cnt++;
    exp_mode = MODE_MAX;
    @(negedge clock);
    total_cnt++;
    if (conv_start !== 1'b1) $display("FAIL press_restart: got %b expected 1", conv_start);
    else pass_cnt++;
    total_cnt++;
    if ({DAY, AVS, MAX, TIM} !== 4'b0010) $display("FAIL press_one_advance: got %b expected 0010", {DAY, AVS, MAX, TIM});
    else pass_cnt++;
    wait_update(20, n, ok);
    total_cnt++;
    if (!ok) $display("FAIL press_second_update: got none within %0d expected update", n);
    else pass_cnt++;
    #1;
    s1 = start_count;
    repeat (10) @(negedge clock);
    #1;
    total_cnt++;
    if (start_count !== s1 || {DAY, AVS, MAX, TIM} !== 4'b0010)
      $display("FAIL press_no_extra: got starts=%0d mode=%b expected starts=%0d mode=0010", start_count - s1 + s1, {DAY, AVS, MAX, TIM}, s1);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    int n, u0;
    bit ok;
    model_reply = 1'b0;
    wait_start(50, n, ok);
    #1;
    u0 = upd_count;
    total_cnt++;
    if (!ok) $display("FAIL timeout_start: got no start within %0d expected start", n);
    else pass_cnt++;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    total_cnt++;
    if (n != TIMEOUT + 1) $display("FAIL timeout_busy_len: got %0d expected %0d", n, TIMEOUT + 1);
    else pass_cnt++;
    total_cnt++;
    if (err_timeout !== 1'b1) $display("FAIL timeout_err: got %b expected 1", err_timeout);
    else pass_cnt++;
    total_cnt++;
    if (disp_all !== last_disp) $display("FAIL timeout_disp_kept: got %h expected %h", disp_all, last_disp);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (upd_count !== u0) $display("FAIL timeout_no_update: got %0d updates expected %0d", upd_count, u0);
    else pass_cnt++;
    model_reply = 1'b1;
    wait_start(50, n, ok);
    total_cnt++;
    if (!ok || n != REFRESH - TIMEOUT - 1)
      $display("FAIL timeout_retry: got ok=%0d n=%0d expected ok=1 n=%0d", ok, n, REFRESH - TIMEOUT - 1);
    else pass_cnt++;
    wait_update(20, n, ok);
    total_cnt++;
    if (!ok || err_timeout !== 1'b1)
      $display("FAIL timeout_retry_done: got ok=%0d err=%b expected ok=1 err=1", ok, err_timeout);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_wait;
    int n, u0;
    bit ok;
    model_reply = 1'b0;
    wait_start(50, n, ok);
    #1;
    u0 = upd_count;
    total_cnt++;
    if (!ok) $display("FAIL rstwait_start: got no start within %0d expected start", n);
    else pass_cnt++;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rstwait_busy: got %b expected 0", busy);
    else pass_cnt++;
    @(negedge clock);
    tb_digits = 48'h313233343536;
    tb_valid  = 1'b1;
    @(negedge clock);
    total_cnt++;
    if (disp_all !== {6{8'h20}}) $display("FAIL rstwait_disp: got %h expected %h", disp_all, {6{8'h20}});
    else pass_cnt++;
    total_cnt++;
    if (disp_update !== 1'b0) $display("FAIL rstwait_update: got %b expected 0", disp_update);
    else pass_cnt++;
    total_cnt++;
    if ({DAY, AVS, MAX, TIM} !== 4'b1000) $display("FAIL rstwait_mode: got %b expected 1000", {DAY, AVS, MAX, TIM});
    else pass_cnt++;
    total_cnt++;
    if (err_timeout !== 1'b0) $display("FAIL rstwait_err: got %b expected 0", err_timeout);
    else pass_cnt++;
    tb_valid = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    total_cnt++;
    if (upd_count !== u0) $display("FAIL rstwait_no_update: got %0d updates expected %0d", upd_count, u0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_conversion();
    test_periodic();
    test_mode_button();
    test_press_during_wait();
    test_timeout();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
